// File: rtl/baby_kyber_pkg.sv
// Shared Baby Kyber definitions: default parameters, coefficient type, sampler states.
package baby_kyber_pkg;

   localparam int ETA_DEF = 2;
   localparam int Q_DEF   = 17;
   localparam int N_DEF   = 4;
   localparam int CW_DEF  = $clog2(Q_DEF);

   typedef logic [CW_DEF-1:0] coef_t;

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_WAIT,
      S_CALC,
      S_EMIT,
      S_DONE
   } sampler_state_t;

endpackage

// File: rtl/cbd_chunk.sv
// Centered-binomial sample of one 2*ETA-bit chunk, folded into [0,Q-1].
module cbd_chunk
   import baby_kyber_pkg::*;
#(
   parameter  int ETA = ETA_DEF,
   parameter  int Q   = Q_DEF,
   localparam int CW  = $clog2(Q)
) (
   input  logic [2*ETA-1:0] chunk,
   output logic [CW-1:0]    coef
);

   logic [3:0] a;
   logic [3:0] b;

   // popcount both halves (low half positive), subtract, fold negatives by adding Q
   always_comb begin
      a = 4'($countones(chunk[ETA-1:0]));
      b = 4'($countones(chunk[2*ETA-1:ETA]));
      if (a >= b) coef = CW'(a - b);
      else        coef = CW'(Q) - CW'(b - a);
   end

endmodule

// File: rtl/cbd_noise_sampler.sv
// Baby Kyber CBD noise sampler: fetches 32-bit random words, slices them
// LSB-first into 2*ETA-bit chunks and streams N coefficients per start.
module cbd_noise_sampler
   import baby_kyber_pkg::*;
#(
   parameter  int ETA = ETA_DEF,
   parameter  int Q   = Q_DEF,
   parameter  int N   = N_DEF,
   localparam int CW  = $clog2(Q)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          start,
   output logic          busy,
   output logic          done,
   output logic          rnd_req,
   input  logic          rnd_valid,
   input  logic [31:0]   rnd_data,
   output logic          coef_valid,
   input  logic          coef_ready,
   output logic [CW-1:0] coef_data,
   output logic          coef_last
);

   localparam int W  = 2 * ETA;
   localparam int IW = $clog2(N + 1);
   // pre-increment pointer above this value means the next chunk would run past bit 31
   localparam logic [5:0] REFILL_AT = 6'(32 - 2 * W);

   if (ETA < 1 || ETA > 8 || ETA >= Q) begin : g_bad_params
      $error("cbd_noise_sampler: ETA must be in 1..8 and below Q");
   end

   sampler_state_t  state;
   logic [31:0]     word;
   logic [5:0]      ptr;
   logic [IW-1:0]   idx;
   logic [31:0]     shifted;
   logic [W-1:0]    chunk;
   logic [CW-1:0]   chunk_coef;

   // select the current chunk from the buffered word
   always_comb begin
      shifted = word >> ptr;
      chunk   = shifted[W-1:0];
   end

   cbd_chunk #(
      .ETA (ETA),
      .Q   (Q)
   ) u_chunk (
      .chunk (chunk),
      .coef  (chunk_coef)
   );

   // sampler FSM with registered outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= S_IDLE;
         busy       <= 1'b0;
         done       <= 1'b0;
         rnd_req    <= 1'b0;
         coef_valid <= 1'b0;
         coef_data  <= '0;
         coef_last  <= 1'b0;
         word       <= '0;
         ptr        <= '0;
         idx        <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (start) begin
                  state   <= S_FETCH;
                  busy    <= 1'b1;
                  rnd_req <= 1'b1;
                  ptr     <= '0;
                  idx     <= '0;
               end
            end
            S_FETCH: begin
               rnd_req <= 1'b0;
               state   <= S_WAIT;
            end
            S_WAIT: begin
               if (rnd_valid) begin
                  word  <= rnd_data;
                  ptr   <= '0;
                  state <= S_CALC;
               end
            end
            S_CALC: begin
               coef_data  <= chunk_coef;
               coef_last  <= (idx == IW'(N - 1));
               coef_valid <= 1'b1;
               state      <= S_EMIT;
            end
            S_EMIT: begin
               if (coef_ready) begin
                  coef_valid <= 1'b0;
                  coef_last  <= 1'b0;
                  ptr        <= ptr + 6'(W);
                  idx        <= idx + 1'b1;
                  if (idx == IW'(N - 1)) begin
                     state <= S_DONE;
                     done  <= 1'b1;
                     busy  <= 1'b0;
                  end else if (ptr > REFILL_AT) begin
                     state   <= S_FETCH;
                     rnd_req <= 1'b1;
                  end else begin
                     state <= S_CALC;
                  end
               end
            end
            S_DONE: begin
               done  <= 1'b0;
               state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule
